multicycle_controller: RTL
==========================

Name: multicycle_controller

Overview:
- Control FSM plus ALU decoder that sequences the multicycle MIPS datapath.
- Consumes `instr[31:26]`/`instr[5:0]` from the instruction register, `zero` from the ALU and `mem_ready` from memory.
- Drives every datapath select and enable strobe, plus `memwrite`.
- Keeps a retired-instruction counter and a sticky illegal-opcode flag for debug.

Parameters:
- CNT_W, 32, width of retired-instruction counter `instret`.

Ports:
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  asynchronous, active-low reset (0 = reset)
- op  in  6  `instr[31:26]`
- funct  in  6  `instr[5:0]`
- zero  in  1  ALU zero flag
- mem_ready  in  1  memory completes access this cycle
- memtoreg  out  1  register write data select (1 = memory data)
- pcsrc  out  1  next-PC select (0 = aluresult, 1 = aluout)
- pcen  out  1  PC register enable
- alusrcA  out  1  ALU A select (0 = pc, 1 = A reg)
- alusrcB  out  2  ALU B select (00 = B reg, 01 = 4, 10 = signimm, 11 = signimm<<2)
- regdst  out  1  destination register select (1 = rd)
- regwrite  out  1  register file write enable
- jump  out  1  jump-target select for PC logic
- iord  out  1  memory address select (1 = aluout)
- irwrite  out  1  instruction register enable
- memwrite  out  1  memory write strobe
- alucontrol  out  3  ALU operation
- state  out  4  current FSM state (debug)
- instret  out  CNT_W  retired instructions
- illegal  out  1  sticky: unknown opcode decoded

Behaviour:
- Reset (reset=0, async):
  - state=FETCH, instret=0, illegal=0.
  - While reset=0, strobes irwrite, pcen, regwrite and memwrite are forced 0.
  - Reset asserted mid-instruction abandons it; no further strobe that cycle.
- Outputs are combinational from state (and op/funct/zero/mem_ready). Unlisted outputs are 0 in every state.
- pcen = pcwrite | (branch & zero). pcwrite and branch are internal.
- ALU decoder, by aluop:
  - 00 → 010 (add).
  - 01 → 110 (sub).
  - 10 → by funct: 100000 → 010, 100010 → 110, 100100 → 000, 100101 → 001, 101010 → 111, any other funct → 010.
- FETCH (0):
  - iord=0, alusrcA=0, alusrcB=01, aluop=00, pcsrc=0.
  - irwrite=pcwrite=mem_ready.
  - Stay while mem_ready=0; go to DECODE when mem_ready=1.
- DECODE (1):
  - alusrcA=0, alusrcB=11, aluop=00 (branch target into aluout).
  - Next state by op: 100011/101011 → MEMADR; 000000 → RTYPEEX; 000100 → BEQEX; 001000 → ADDIEX; 000010 → JEX.
  - Any other op → FETCH, set illegal, no instret increment.
- MEMADR (2): alusrcA=1, alusrcB=10, aluop=00. Go to MEMRD if op=100011, else MEMWR.
- MEMRD (3): iord=1. Wait for mem_ready=1, then MEMWB.
- MEMWB (4): regdst=0, memtoreg=1, regwrite=1. Then FETCH.
- MEMWR (5): iord=1, memwrite=1 (held each cycle while waiting). Go to FETCH when mem_ready=1.
- RTYPEEX (6): alusrcA=1, alusrcB=00, aluop=10. Then RTYPEWB.
- RTYPEWB (7): regdst=1, memtoreg=0, regwrite=1. Then FETCH.
- BEQEX (8): alusrcA=1, alusrcB=00, aluop=01, branch=1, pcsrc=1. Then FETCH.
- ADDIEX (9): alusrcA=1, alusrcB=10, aluop=00. Then ADDIWB.
- ADDIWB (10): regdst=0, memtoreg=0, regwrite=1. Then FETCH.
- JEX (11): jump=1, pcwrite=1, pcsrc=0. Then FETCH.
- Encodings 12–15 are unreachable; if entered, next state is FETCH with all strobes 0.
- instret:
  - Increments by 1 on each transition into FETCH from MEMWB, MEMWR, RTYPEWB, BEQEX, ADDIWB or JEX.
  - Wraps modulo 2^CNT_W.
  - No increment for a branch not taken vs taken difference; both count.
- illegal stays 1 until reset.
- Cycle counts with mem_ready tied 1: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3.

Test Plan:
- Reset low then high with mem_ready=1, op=000000, funct=100010 → states 0,1,6,7,0; alucontrol=110 in state 6; regwrite=1, regdst=1 in state 7; instret=1.
- lw (op=100011) with mem_ready=0 for 3 cycles in MEMRD → state stays 3 for 4 cycles total; MEMWB asserts memtoreg=1, regwrite=1; lw totals 8 cycles; instret=1.
- beq (op=000100) in BEQEX: zero=1 → pcen=1, pcsrc=1, alucontrol=110; with zero=0 → pcen=0; both cases instret increments.
- sw (op=101011), mem_ready low 2 cycles in MEMWR → memwrite=1 for 3 cycles, iord=1; FETCH with mem_ready=0 keeps irwrite=0, pcen=0.
- op=111111 at DECODE → next state FETCH, illegal=1 (sticky through a following addi), instret unchanged; addi then gives alusrcB=10 in state 9, regwrite=1 in state 10.
- Assert reset in RTYPEWB → immediately state=0, regwrite=0, irwrite=0, instret=0, illegal=0. Preload instret to all-ones (CNT_W=4, 15 retires) then one more → instret wraps to 0.

Source files
------------

// File: rtl/multicycle_controller.sv
// Control FSM and ALU decoder that sequences a multicycle MIPS datapath.
// Also tracks retired instructions and latches a sticky illegal-opcode flag.
module multicycle_controller #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       op,
  input  logic [5:0]       funct,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             memtoreg,
  output logic             pcsrc,
  output logic             pcen,
  output logic             alusrcA,
  output logic [1:0]       alusrcB,
  output logic             regdst,
  output logic             regwrite,
  output logic             jump,
  output logic             iord,
  output logic             irwrite,
  output logic             memwrite,
  output logic [2:0]       alucontrol,
  output logic [3:0]       state,
  output logic [CNT_W-1:0] instret,
  output logic             illegal
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_RTYPEEX = 4'd6,
    S_RTYPEWB = 4'd7,
    S_BEQEX   = 4'd8,
    S_ADDIEX  = 4'd9,
    S_ADDIWB  = 4'd10,
    S_JEX     = 4'd11
  } state_t;

  state_t     cur, nxt;
  logic [1:0] aluop;
  logic       pcwrite, branch;
  logic       irwrite_raw, regwrite_raw, memwrite_raw;
  logic       retire, bad_op;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) cur <= S_FETCH;
    else        cur <= nxt;
  end

  always_comb begin
    nxt          = S_FETCH;
    memtoreg     = 1'b0;
    pcsrc        = 1'b0;
    alusrcA      = 1'b0;
    alusrcB      = 2'b00;
    regdst       = 1'b0;
    regwrite_raw = 1'b0;
    jump         = 1'b0;
    iord         = 1'b0;
    irwrite_raw  = 1'b0;
    memwrite_raw = 1'b0;
    pcwrite      = 1'b0;
    branch       = 1'b0;
    aluop        = 2'b00;
    retire       = 1'b0;
    bad_op       = 1'b0;
    case (cur)
      S_FETCH: begin
        alusrcB     = 2'b01;
        irwrite_raw = mem_ready;
        pcwrite     = mem_ready;
        nxt         = mem_ready ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        // Branch target is computed here so BEQEX can use it from aluout.
        alusrcB = 2'b11;
        case (op)
          OP_LW, OP_SW: nxt = S_MEMADR;
          OP_RTYPE:     nxt = S_RTYPEEX;
          OP_BEQ:       nxt = S_BEQEX;
          OP_ADDI:      nxt = S_ADDIEX;
          OP_J:         nxt = S_JEX;
          default: begin
            nxt    = S_FETCH;
            bad_op = 1'b1;
          end
        endcase
      end
      S_MEMADR: begin
        alusrcA = 1'b1;
        alusrcB = 2'b10;
        nxt     = (op == OP_LW) ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        iord = 1'b1;
        nxt  = mem_ready ? S_MEMWB : S_MEMRD;
      end
      S_MEMWB: begin
        memtoreg     = 1'b1;
        regwrite_raw = 1'b1;
        retire       = 1'b1;
      end
      S_MEMWR: begin
        iord         = 1'b1;
        memwrite_raw = 1'b1;
        retire       = mem_ready;
        nxt          = mem_ready ? S_FETCH : S_MEMWR;
      end
      S_RTYPEEX: begin
        alusrcA = 1'b1;
        aluop   = 2'b10;
        nxt     = S_RTYPEWB;
      end
      S_RTYPEWB: begin
        regdst       = 1'b1;
        regwrite_raw = 1'b1;
        retire       = 1'b1;
      end
      S_BEQEX: begin
        alusrcA = 1'b1;
        aluop   = 2'b01;
        branch  = 1'b1;
        pcsrc   = 1'b1;
        retire  = 1'b1;
      end
      S_ADDIEX: begin
        alusrcA = 1'b1;
        alusrcB = 2'b10;
        nxt     = S_ADDIWB;
      end
      S_ADDIWB: begin
        regwrite_raw = 1'b1;
        retire       = 1'b1;
      end
      S_JEX: begin
        jump    = 1'b1;
        pcwrite = 1'b1;
        retire  = 1'b1;
      end
      default: nxt = S_FETCH;
    endcase
  end

  always_comb begin
    alucontrol = 3'b010;
    case (aluop)
      2'b01: alucontrol = 3'b110;
      2'b10: begin
        case (funct)
          6'b100010: alucontrol = 3'b110;
          6'b100100: alucontrol = 3'b000;
          6'b100101: alucontrol = 3'b001;
          6'b101010: alucontrol = 3'b111;
          default:   alucontrol = 3'b010;
        endcase
      end
      default: alucontrol = 3'b010;
    endcase
  end

  // Strobes are masked by reset so an abandoned instruction writes nothing.
  assign irwrite  = irwrite_raw & reset;
  assign regwrite = regwrite_raw & reset;
  assign memwrite = memwrite_raw & reset;
  assign pcen     = (pcwrite | (branch & zero)) & reset;
  assign state    = cur;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      instret <= '0;
      illegal <= 1'b0;
    end else begin
      if (retire) instret <= instret + CNT_W'(1);
      if (bad_op) illegal <= 1'b1;
    end
  end

endmodule
